// File: rtl/isp_expo_responder.sv
`default_nettype none
// ============================================================================
// isp_expo_responder: fetches a 3x32x32 picture, applies the exposure ratio,
// streams adjusted bytes back and reports the average gray level.
// Optional result cache: define ISP_EXPO_CACHE_EN.   Rev 1.0
// ============================================================================
module isp_expo_responder #(
    parameter int                 ADDR_W    = 17,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 17'h10000,
    parameter int                 PIC_BYTES = 3072
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        in_pic_no,
    input  logic [1:0]        in_ratio_mode,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              wb_valid,
    output logic [7:0]        wb_data,
    output logic              busy,
    output logic              out_valid,
    output logic [7:0]        out_data
);

    localparam logic [2:0]  S_IDLE    = 3'd0;
    localparam logic [2:0]  S_REQ     = 3'd1;
    localparam logic [2:0]  S_RECV    = 3'd2;
    localparam logic [2:0]  S_FLUSH   = 3'd3;
    localparam logic [2:0]  S_DONE    = 3'd4;
    localparam logic [2:0]  S_HIT     = 3'd5;
    localparam logic [11:0] LAST_BEAT = 12'(PIC_BYTES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  pic_q;
    logic [1:0]  ratio_q;
    logic [11:0] cnt_q;
    logic [17:0] acc_q;
    logic        wb_valid_q;
    logic [7:0]  wb_data_q;

    logic        cache_hit;
    logic [7:0]  cache_res;
    logic [7:0]  adj;
    logic [7:0]  contrib;
    logic        beat;
    logic        accept;

    assign accept = (state_q == S_IDLE) && in_valid;
    assign beat   = (state_q == S_RECV) && pix_valid;

    always_comb begin
        adj = pix_data;
        case (ratio_q)
            2'd0:    adj = {2'b00, pix_data[7:2]};
            2'd1:    adj = {1'b0, pix_data[7:1]};
            2'd2:    adj = pix_data;
            default: adj = pix_data[7] ? 8'hFF : {pix_data[6:0], 1'b0};
        endcase
    end

    // Gray weighting 1/4 R + 1/2 G + 1/4 B; channel comes from the beat count.
    assign contrib = (cnt_q[11:10] == 2'd1) ? {1'b0, adj[7:1]} : {2'b00, adj[7:2]};

`ifdef ISP_EXPO_CACHE_EN
    logic [15:0] cvld_q;
    logic [7:0]  cres_q [16];

    assign cache_hit = in_valid && (in_ratio_mode == 2'd2) && cvld_q[in_pic_no];
    assign cache_res = cres_q[in_pic_no];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cvld_q <= '0;
        end else if (state_q == S_DONE) begin
            cvld_q[pic_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_DONE) begin
            cres_q[pic_q] <= acc_q[17:10];
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = cache_hit ? S_HIT : S_REQ;
            S_REQ:   if (rd_ack) state_d = S_RECV;
            S_RECV:  if (pix_valid && (cnt_q == LAST_BEAT)) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            S_HIT:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_req    = (state_q == S_REQ);
        rd_addr   = '0;
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        out_data  = '0;
        wb_valid  = wb_valid_q;
        wb_data   = wb_data_q;
        if (state_q == S_REQ) begin
            rd_addr = BASE_ADDR + ADDR_W'(pic_q) * ADDR_W'(PIC_BYTES);
        end
        if (state_q == S_DONE) begin
            out_data = acc_q[17:10];
        end
    end

    // A cache hit preloads the accumulator so DONE reads the result uniformly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pic_q      <= '0;
            ratio_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= beat;
            wb_data_q  <= beat ? adj : 8'd0;
            if (accept) begin
                pic_q   <= in_pic_no;
                ratio_q <= in_ratio_mode;
                cnt_q   <= '0;
                acc_q   <= {(cache_hit ? cache_res : 8'd0), 10'd0};
            end else if (beat) begin
                cnt_q <= cnt_q + 12'd1;
                acc_q <= acc_q + {10'd0, contrib};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_isp_expo_responder.sv
`default_nettype none
// ============================================================================
// tb_isp_expo_responder: directed self-checking bench for isp_expo_responder.
// Rev 1.0
// ============================================================================
module tb_isp_expo_responder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_pic_no;
    logic [1:0]  in_ratio_mode;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        rd_ack;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        wb_valid;
    logic [7:0]  wb_data;
    logic        busy;
    logic        out_valid;
    logic [7:0]  out_data;

    int checks   = 0;
    int failures = 0;
    int wb_cnt   = 0;
    int wb_err   = 0;
    int ov_cnt   = 0;
    logic [7:0] exp_wb = 8'h00;

    isp_expo_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_pic_no     (in_pic_no),
        .in_ratio_mode (in_ratio_mode),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_ack        (rd_ack),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_data      (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_valid) begin
            wb_cnt++;
            if (wb_data !== exp_wb) wb_err++;
        end
        if (out_valid) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_req"},    32'(rd_req),    0);
        chk({tag, "_rd_addr"},   32'(rd_addr),   0);
        chk({tag, "_wb_valid"},  32'(wb_valid),  0);
        chk({tag, "_wb_data"},   32'(wb_data),   0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"},  32'(out_data),  0);
    endtask

    task automatic start_cmd(input logic [3:0] pic, input logic [1:0] ratio, input logic [7:0] ewb);
        exp_wb = ewb;
        wb_cnt = 0;
        wb_err = 0;
        ov_cnt = 0;
        @(negedge clk);
        in_valid      = 1'b1;
        in_pic_no     = pic;
        in_ratio_mode = ratio;
        @(negedge clk);
        in_valid      = 1'b0;
        in_pic_no     = 4'd0;
        in_ratio_mode = 2'd0;
    endtask

    // Handshake the read request; junk pix_valid beats during REQ must be ignored.
    task automatic do_req(input string tag, input logic [16:0] eaddr);
        int guard;
        pix_valid = 1'b1;
        pix_data  = 8'h00;
        chk({tag, "_busy"}, 32'(busy), 1);
        guard = 0;
        while (!rd_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_rd_req"}, 32'(rd_req), 1);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(eaddr));
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        chk({tag, "_rd_req_drop"}, 32'(rd_req), 0);
    endtask

    task automatic drive_beats(input int nbeats, input logic [7:0] pb, input bit gaps);
        int n;
        n = 0;
        while (n < nbeats) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                pix_valid     = 1'b0;
                pix_data      = 8'($urandom);
                in_valid      = 1'($urandom_range(0, 1));
                in_pic_no     = 4'($urandom);
                in_ratio_mode = 2'($urandom);
                rd_ack        = 1'($urandom_range(0, 1));
            end else begin
                pix_valid = 1'b1;
                pix_data  = pb;
                in_valid  = 1'b0;
                rd_ack    = 1'b0;
                n++;
            end
            @(negedge clk);
        end
        pix_valid     = 1'b0;
        pix_data      = 8'h00;
        in_valid      = 1'b0;
        in_pic_no     = 4'd0;
        in_ratio_mode = 2'd0;
        rd_ack        = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input logic [7:0] eout);
        chk({tag, "_ov_flush"}, 32'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_ov"}, 32'(out_valid), 1);
        chk({tag, "_out_data"}, 32'(out_data), 32'(eout));
        chk({tag, "_busy_done"}, 32'(busy), 1);
        @(negedge clk);
        chk({tag, "_ov_end"}, 32'(out_valid), 0);
        chk({tag, "_od_end"}, 32'(out_data), 0);
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_wb_cnt"}, 32'(wb_cnt), 3072);
        chk({tag, "_wb_err"}, 32'(wb_err), 0);
        chk({tag, "_ov_cnt"}, 32'(ov_cnt), 1);
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] pic, input logic [1:0] ratio,
                           input logic [7:0] pb, input logic [7:0] ewb, input logic [7:0] eout,
                           input logic [16:0] eaddr, input bit gaps);
        start_cmd(pic, ratio, ewb);
        do_req(tag, eaddr);
        drive_beats(3072, pb, gaps);
        finish_cmd(tag, eout);
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_pic_no     = 4'd0;
        in_ratio_mode = 2'd0;
        rd_ack        = 1'b0;
        pix_valid     = 1'b0;
        pix_data      = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        rd_ack = 1'b1;
        pix_valid = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        pix_valid = 1'b0;
        chk_all_zero("idle_ignore");

        run_cmd("p5_r2",  4'd5,  2'd2, 8'h80, 8'h80, 8'd128, 17'h13C00, 1'b0);
        run_cmd("p0_r3a", 4'd0,  2'd3, 8'h80, 8'hFF, 8'd253, 17'h10000, 1'b0);
        run_cmd("p0_r3b", 4'd0,  2'd3, 8'h40, 8'h80, 8'd128, 17'h10000, 1'b0);
        run_cmd("p15_r0", 4'd15, 2'd0, 8'hFF, 8'h3F, 8'd61,  17'h1B400, 1'b0);
        run_cmd("p15_r1", 4'd15, 2'd1, 8'hFF, 8'h7F, 8'd125, 17'h1B400, 1'b0);
        run_cmd("p7_gap", 4'd7,  2'd1, 8'h9C, 8'h4E, 8'd77,  17'h15400, 1'b1);
        run_cmd("p7_nog", 4'd7,  2'd1, 8'h9C, 8'h4E, 8'd77,  17'h15400, 1'b0);

        // Abort mid-receive with an asynchronous reset.
        start_cmd(4'd9, 2'd2, 8'h80);
        do_req("abort", 17'h16C00);
        drive_beats(1500, 8'h80, 1'b0);
        pix_valid = 1'b1;
        pix_data  = 8'h80;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ov_cnt = 0;
        wb_cnt = 0;
        repeat (5) @(negedge clk);
        chk("abort_no_ov", 32'(ov_cnt), 0);
        chk("abort_no_wb", 32'(wb_cnt), 0);
        run_cmd("p9_after", 4'd9, 2'd2, 8'h33, 8'h33, 8'd49, 17'h16C00, 1'b0);

        run_cmd("p3_r3", 4'd3, 2'd3, 8'h40, 8'h80, 8'd128, 17'h12400, 1'b0);
`ifdef ISP_EXPO_CACHE_EN
        ov_cnt = 0;
        wb_cnt = 0;
        @(negedge clk);
        in_valid      = 1'b1;
        in_pic_no     = 4'd3;
        in_ratio_mode = 2'd2;
        @(negedge clk);
        in_valid      = 1'b0;
        chk("hit_rd_req", 32'(rd_req), 0);
        chk("hit_ov_early", 32'(out_valid), 0);
        @(negedge clk);
        chk("hit_rd_req2", 32'(rd_req), 0);
        chk("hit_ov", 32'(out_valid), 1);
        chk("hit_out_data", 32'(out_data), 128);
        @(negedge clk);
        chk("hit_ov_end", 32'(out_valid), 0);
        chk("hit_wb_cnt", 32'(wb_cnt), 0);
        chk("hit_ov_cnt", 32'(ov_cnt), 1);
`else
        run_cmd("p3_r2", 4'd3, 2'd2, 8'h10, 8'h10, 8'd16, 17'h12400, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
